// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decoder/writeback/memory-response bus of the scoreboarded register file
interface regfile_scoreboard_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3
);
   logic [ADDR_W-1:0]   rd_addr_a;
   logic [ADDR_W-1:0]   rd_addr_b;
   logic [DATA_W-1:0]   rd_data_a;
   logic [DATA_W-1:0]   rd_data_b;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                ld_issue;
   logic [ADDR_W-1:0]   ld_dst;
   logic                ld_resp_valid;
   logic [ADDR_W-1:0]   ld_resp_addr;
   logic [DATA_W-1:0]   ld_resp_data;
   logic                stall;
   logic [NUM_REGS-1:0] busy_vec;
   logic [ADDR_W:0]     pending_cnt;
   logic                resp_err;
   modport master (
      output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, ld_issue, ld_dst,
             ld_resp_valid, ld_resp_addr, ld_resp_data,
      input  rd_data_a, rd_data_b, stall, busy_vec, pending_cnt, resp_err
   );
   modport slave (
      input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, ld_issue, ld_dst,
             ld_resp_valid, ld_resp_addr, ld_resp_data,
      output rd_data_a, rd_data_b, stall, busy_vec, pending_cnt, resp_err
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with load scoreboard, same-cycle bypass and pipeline stall
module regfile_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   regfile_scoreboard_if.slave bus
);
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic                err;
   logic [ADDR_W:0]     cnt;
   logic                z_a, z_b, z_wr, z_ld, z_rsp;
   logic                resp_hit, resp_bad;
   logic                hz_a, hz_b, hz_w, stall;
   logic                wr_ok, iss_ok;

   // Register 0 is hard-wired only when ZERO_REG is set; these flag accesses to it.
   assign z_a   = ZERO_REG && bus.rd_addr_a == '0;
   assign z_b   = ZERO_REG && bus.rd_addr_b == '0;
   assign z_wr  = ZERO_REG && bus.wr_addr == '0;
   assign z_ld  = ZERO_REG && bus.ld_dst == '0;
   assign z_rsp = ZERO_REG && bus.ld_resp_addr == '0;

   // A response only lands on a register that is waiting for it; reg 0 is never
   // marked busy when hard-wired, so it can never be hit.
   assign resp_hit = bus.ld_resp_valid && busy[bus.ld_resp_addr];
   assign resp_bad = bus.ld_resp_valid && !busy[bus.ld_resp_addr] && !z_rsp;

   // A returning response resolves the hazard it would otherwise raise this cycle.
   assign hz_a  = busy[bus.rd_addr_a] && !(bus.ld_resp_valid && bus.ld_resp_addr == bus.rd_addr_a);
   assign hz_b  = busy[bus.rd_addr_b] && !(bus.ld_resp_valid && bus.ld_resp_addr == bus.rd_addr_b);
   assign hz_w  = (bus.wr_en && busy[bus.wr_addr]) ||
                  (bus.ld_issue && busy[bus.ld_dst] && !(bus.ld_resp_valid && bus.ld_resp_addr == bus.ld_dst));
   assign stall = hz_a | hz_b | hz_w;

   assign wr_ok  = bus.wr_en && !stall && !z_wr;
   assign iss_ok = bus.ld_issue && !stall && !z_ld;

   // Bypass order: load response, then ALU write, then the array.
   assign bus.rd_data_a = z_a ? '0 :
                          (resp_hit && bus.ld_resp_addr == bus.rd_addr_a) ? bus.ld_resp_data :
                          (wr_ok && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data : regs[bus.rd_addr_a];
   assign bus.rd_data_b = z_b ? '0 :
                          (resp_hit && bus.ld_resp_addr == bus.rd_addr_b) ? bus.ld_resp_data :
                          (wr_ok && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data : regs[bus.rd_addr_b];

   assign bus.stall       = stall;
   assign bus.busy_vec    = busy;
   assign bus.pending_cnt = cnt;
   assign bus.resp_err    = err;

   // Response clears first so that a same-cycle issue to that register keeps it busy.
   always_comb begin
      busy_nxt = busy;
      if (resp_hit) busy_nxt[bus.ld_resp_addr] = 1'b0;
      if (iss_ok) busy_nxt[bus.ld_dst] = 1'b1;
   end

   // Pending count tracks the live scoreboard bits.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_REGS; i++) cnt = cnt + (ADDR_W+1)'(busy[i]);
   end

   // Scoreboard and sticky error; the error never clears outside reset.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         busy <= '0;
         err  <= 1'b0;
      end else begin
         busy <= busy_nxt;
         err  <= err | resp_bad;
      end

   // Register array; a legal ALU write and response never share a target, the response is last anyway.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
         if (resp_hit) regs[bus.ld_resp_addr] <= bus.ld_resp_data;
      end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard bench for regfile_scoreboard (hard-wired zero and plain variants)
module tb_regfile_scoreboard;
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        stall;
      logic [7:0]  busy;
      logic [3:0]  cnt;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   exp_t        q[$];
   logic [15:0] m_regs [8];
   logic [7:0]  m_busy;
   logic        m_err;

   always #5 clk = ~clk;

   regfile_scoreboard_if #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) bus ();
   regfile_scoreboard_if #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) bus0 ();

   regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave));
   regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave));

   assign bus0.rd_addr_a     = bus.rd_addr_a;
   assign bus0.rd_addr_b     = bus.rd_addr_b;
   assign bus0.wr_en         = bus.wr_en;
   assign bus0.wr_addr       = bus.wr_addr;
   assign bus0.wr_data       = bus.wr_data;
   assign bus0.ld_issue      = bus.ld_issue;
   assign bus0.ld_dst        = bus.ld_dst;
   assign bus0.ld_resp_valid = bus.ld_resp_valid;
   assign bus0.ld_resp_addr  = bus.ld_resp_addr;
   assign bus0.ld_resp_data  = bus.ld_resp_data;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [15:0] rd_model(input logic [2:0] addr, input logic st, input logic hit);
      if (addr == 3'd0) return 16'h0;
      if (hit && bus.ld_resp_addr == addr) return bus.ld_resp_data;
      if (bus.wr_en && !st && bus.wr_addr == addr) return bus.wr_data;
      return m_regs[addr];
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      logic ha, hb, hw, hit;
      ha = m_busy[bus.rd_addr_a] && !(bus.ld_resp_valid && bus.ld_resp_addr == bus.rd_addr_a);
      hb = m_busy[bus.rd_addr_b] && !(bus.ld_resp_valid && bus.ld_resp_addr == bus.rd_addr_b);
      hw = (bus.wr_en && m_busy[bus.wr_addr]) ||
           (bus.ld_issue && m_busy[bus.ld_dst] && !(bus.ld_resp_valid && bus.ld_resp_addr == bus.ld_dst));
      hit = bus.ld_resp_valid && m_busy[bus.ld_resp_addr];
      e.stall = ha | hb | hw;
      e.a = rd_model(bus.rd_addr_a, e.stall, hit);
      e.b = rd_model(bus.rd_addr_b, e.stall, hit);
      e.busy = m_busy;
      e.cnt = 4'($countones(m_busy));
      e.err = m_err;
      return e;
   endfunction

   task automatic apply(input logic [2:0] ra, input logic [2:0] rb, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic li, input logic [2:0] ld, input logic rv,
                        input logic [2:0] rsa, input logic [15:0] rsd);
      exp_t e;
      bus.rd_addr_a = ra; bus.rd_addr_b = rb;
      bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
      bus.ld_issue = li; bus.ld_dst = ld;
      bus.ld_resp_valid = rv; bus.ld_resp_addr = rsa; bus.ld_resp_data = rsd;
      q.push_back(model_out());
      #1;
      e = q.pop_front();
      check("rd_data_a", bus.rd_data_a, e.a);
      check("rd_data_b", bus.rd_data_b, e.b);
      check("stall", 16'(bus.stall), 16'(e.stall));
      check("busy_vec", 16'(bus.busy_vec), 16'(e.busy));
      check("pending_cnt", 16'(bus.pending_cnt), 16'(e.cnt));
      check("resp_err", 16'(bus.resp_err), 16'(e.err));
   endtask

   task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
      apply(ra, rb, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_busy = 8'h0;
      m_err = 1'b0;
   endtask

   task automatic tick();
      exp_t e;
      e = model_out();
      @(posedge clk);
      if (bus.ld_resp_valid && bus.ld_resp_addr != 3'd0) begin
         if (m_busy[bus.ld_resp_addr]) begin
            m_regs[bus.ld_resp_addr] = bus.ld_resp_data;
            m_busy[bus.ld_resp_addr] = 1'b0;
         end else m_err = 1'b1;
      end
      if (bus.wr_en && !e.stall && bus.wr_addr != 3'd0) m_regs[bus.wr_addr] = bus.wr_data;
      if (bus.ld_issue && !e.stall && bus.ld_dst != 3'd0) m_busy[bus.ld_dst] = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      idle(3'd3, 3'd5);
      rst = 1'b1;
      @(negedge clk);
      // mid-run asynchronous reset with live data, a busy bit and the error flag
      apply(3'd3, 3'd0, 1'b1, 3'd3, 16'h1234, 1'b1, 3'd6, 1'b0, 3'd0, 16'h0);
      tick();
      apply(3'd3, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd7, 16'h5555);
      tick();
      idle(3'd3, 3'd6);
      check("pre_reset_r3", bus.rd_data_a, 16'h1234);
      rst = 1'b0;
      model_reset();
      #1;
      check("async_r3", bus.rd_data_a, 16'h0);
      check("async_busy", 16'(bus.busy_vec), 16'h0);
      check("async_err", 16'(bus.resp_err), 16'h0);
      idle(3'd3, 3'd6);
      @(negedge clk);
      rst = 1'b1;
      // write bypass on port A
      apply(3'd2, 3'd1, 1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
      check("bypass_a", bus.rd_data_a, 16'hBEEF);
      tick();
      idle(3'd1, 3'd2);
      check("array_r2", bus.rd_data_b, 16'hBEEF);
      // load hazard and response bypass
      apply(3'd1, 3'd2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0);
      tick();
      idle(3'd5, 3'd2);
      check("ld_stall", 16'(bus.stall), 16'h1);
      check("ld_busy", 16'(bus.busy_vec), 16'h20);
      check("ld_cnt", 16'(bus.pending_cnt), 16'h1);
      apply(3'd5, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd5, 16'h00A5);
      check("resp_byp", bus.rd_data_a, 16'h00A5);
      tick();
      idle(3'd5, 3'd2);
      check("resp_clear", 16'(bus.busy_vec), 16'h0);
      // WAW block then response
      apply(3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0);
      tick();
      apply(3'd1, 3'd1, 1'b1, 3'd4, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
      check("waw_stall", 16'(bus.stall), 16'h1);
      tick();
      idle(3'd4, 3'd1);
      check("waw_hold", bus.rd_data_a, 16'h0);
      apply(3'd1, 3'd1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd4, 16'h2222);
      tick();
      idle(3'd4, 3'd1);
      check("waw_resp", bus.rd_data_a, 16'h2222);
      // response and re-issue to the same register in one cycle
      apply(3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0);
      tick();
      apply(3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b1, 3'd1, 16'h0077);
      check("simul_stall", 16'(bus.stall), 16'h0);
      tick();
      idle(3'd1, 3'd2);
      check("simul_r1", bus.rd_data_a, 16'h0077);
      check("simul_busy", 16'(bus.busy_vec), 16'h02);
      check("simul_cnt", 16'(bus.pending_cnt), 16'h1);
      apply(3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd1, 16'h0078);
      tick();
      // hard-wired zero versus plain register 0
      apply(3'd0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
      check("z0_byp", bus0.rd_data_a, 16'hFFFF);
      tick();
      apply(3'd0, 3'd2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b0, 3'd0, 16'h0);
      check("z_read", bus.rd_data_a, 16'h0);
      check("z0_read", bus0.rd_data_a, 16'hFFFF);
      tick();
      idle(3'd2, 3'd2);
      check("z_busy0", 16'(bus.busy_vec[0]), 16'h0);
      check("z0_busy0", 16'(bus0.busy_vec[0]), 16'h1);
      apply(3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd0, 16'h4321);
      tick();
      idle(3'd0, 3'd2);
      check("z_resp_err", 16'(bus.resp_err), 16'h0);
      check("z0_resp", bus0.rd_data_a, 16'h4321);
      // response to a non-busy register
      apply(3'd2, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd6, 16'hDEAD);
      tick();
      idle(3'd6, 3'd2);
      check("err_r6", bus.rd_data_a, 16'h0);
      check("err_set", 16'(bus.resp_err), 16'h1);
      tick();
      idle(3'd6, 3'd2);
      check("err_sticky", 16'(bus.resp_err), 16'h1);
      // random traffic against the model
      for (int n = 0; n < 60; n++) begin
         apply(3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)), 3'($urandom_range(7)),
               16'($urandom), 1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)),
               3'($urandom_range(7)), 16'($urandom));
         tick();
      end
      idle(3'd1, 3'd2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
